// File: rtl/left_shift_normalizer_if.sv
// ============================================================================
// Module   : left_shift_normalizer_if
// Brief    : Input and output valid/ready stream bundle for the normalizer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface left_shift_normalizer_if #(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 8,
  parameter int S_WIDTH   = 4
);
  // upstream side
  logic                 i_valid;
  logic                 o_ready;
  logic [IN_WIDTH-1:0]  i_data;
  logic                 i_last;
  // downstream side
  logic                 o_valid;
  logic                 i_ready;
  logic [OUT_WIDTH-1:0] o_data;
  logic [S_WIDTH-1:0]   o_shift;
  logic                 o_last;

  modport master (
    output i_valid, i_data, i_last, i_ready,
    input  o_ready, o_valid, o_data, o_shift, o_last
  );

  modport slave (
    input  i_valid, i_data, i_last, i_ready,
    output o_ready, o_valid, o_data, o_shift, o_last
  );
endinterface

`default_nettype wire

// File: rtl/left_shift_normalizer.sv
// ============================================================================
// Module   : left_shift_normalizer
// Brief    : Two-stage block-floating-point normalizer: redundant sign-bit
//            count, clamp, left shift and top-bit slice, valid/ready on both sides.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module left_shift_normalizer #(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 8,
  parameter int S_WIDTH   = 4,
  parameter int MAX_SHIFT = 15
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  left_shift_normalizer_if.slave   io_bus
);

  localparam int CNT_W = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;

  // stage 1: input value with its clamped sign-bit count
  logic                 r_s1_valid;
  logic [IN_WIDTH-1:0]  r_s1_data;
  logic [S_WIDTH-1:0]   r_s1_count;
  logic                 r_s1_last;

  // stage 2: output mantissa with its shift count
  logic                 r_s2_valid;
  logic [OUT_WIDTH-1:0] r_s2_mant;
  logic [S_WIDTH-1:0]   r_s2_count;
  logic                 r_s2_last;

  logic                 w_adv1;
  logic                 w_adv2;
  logic                 w_run;
  logic [CNT_W-1:0]     w_cnt;
  logic [S_WIDTH-1:0]   w_count;
  logic [IN_WIDTH-1:0]  w_shifted;
  logic [OUT_WIDTH-1:0] w_mant;

  assign w_adv2 = !r_s2_valid || io_bus.i_ready;
  assign w_adv1 = !r_s1_valid || w_adv2;

  // Length of the run of bits directly below the MSB that copy the MSB.
  always_comb begin
    w_cnt = '0;
    w_run = 1'b1;
    for (int i = IN_WIDTH - 2; i >= 0; i--) begin
      if (w_run && (io_bus.i_data[i] == io_bus.i_data[IN_WIDTH-1])) begin
        w_cnt = w_cnt + CNT_W'(1);
      end else begin
        w_run = 1'b0;
      end
    end
  end

  always_comb begin
    w_count = S_WIDTH'(w_cnt);
    if (int'(w_cnt) > MAX_SHIFT) begin
      w_count = S_WIDTH'(MAX_SHIFT);
    end
  end

  // The count never exceeds the redundant sign bits, so the sign survives.
  assign w_shifted = r_s1_data << r_s1_count;
  assign w_mant    = w_shifted[IN_WIDTH-1 -: OUT_WIDTH];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_s1_count <= '0;
      r_s1_last  <= 1'b0;
    end else if (w_adv1) begin
      r_s1_valid <= io_bus.i_valid;
      if (io_bus.i_valid) begin
        r_s1_data  <= io_bus.i_data;
        r_s1_count <= w_count;
        r_s1_last  <= io_bus.i_last;
      end
    end
  end

  // Payload loads only with a valid beat, so idle-bus garbage never lands here.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s2_valid <= 1'b0;
      r_s2_mant  <= '0;
      r_s2_count <= '0;
      r_s2_last  <= 1'b0;
    end else if (w_adv2) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_mant  <= w_mant;
        r_s2_count <= r_s1_count;
        r_s2_last  <= r_s1_last;
      end
    end
  end

  assign io_bus.o_ready = w_adv1;
  assign io_bus.o_valid = r_s2_valid;
  assign io_bus.o_data  = r_s2_mant;
  assign io_bus.o_shift = r_s2_count;
  assign io_bus.o_last  = r_s2_last;

endmodule

`default_nettype wire

// File: tb/tb_left_shift_normalizer.sv
// ============================================================================
// Module   : tb_left_shift_normalizer
// Brief    : Self-checking bench for left_shift_normalizer (default and
//            MAX_SHIFT=4 instances) against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_left_shift_normalizer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  left_shift_normalizer_if #(.IN_WIDTH(16), .OUT_WIDTH(8), .S_WIDTH(4)) bus ();
  left_shift_normalizer_if #(.IN_WIDTH(16), .OUT_WIDTH(8), .S_WIDTH(4)) bus4 ();

  left_shift_normalizer #(
    .IN_WIDTH(16), .OUT_WIDTH(8), .S_WIDTH(4), .MAX_SHIFT(15)
  ) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus)
  );

  left_shift_normalizer #(
    .IN_WIDTH(16), .OUT_WIDTH(8), .S_WIDTH(4), .MAX_SHIFT(4)
  ) dut4 (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus4)
  );

  typedef struct {
    logic [15:0] d;
    logic        l;
  } beat_t;

  beat_t       q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  bit          prev_stall = 1'b0;
  logic [12:0] prev_out;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Largest shift k <= maxs for which value*2^k still fits a signed 16-bit word.
  function automatic void ref_norm(input logic [15:0] d, input int maxs,
                                   output logic [7:0] m, output logic [3:0] s);
    longint v;
    longint p;
    int     k;
    v = longint'($signed(d));
    k = maxs;
    while (k > 0 && ((v * (64'sd1 << k)) > 32767 || (v * (64'sd1 << k)) < -32768)) k--;
    p = v * (64'sd1 << k);
    m = 8'(p >>> 8);
    s = 4'(k);
  endfunction

  // Evaluate one cycle of the default instance: handshakes seen before the edge.
  task automatic tick(output bit acc);
    beat_t      b;
    logic [7:0] em;
    logic [3:0] es;
    int         rt;
    int         ex;
    #1;
    if (prev_stall)
      chk("hold", {bus.o_valid, bus.o_data, bus.o_shift, bus.o_last}, {1'b1, prev_out});
    acc = bus.i_valid && bus.o_ready;
    if (acc) q.push_back('{bus.i_data, bus.i_last});
    if (bus.o_valid && bus.i_ready) begin
      if (q.size() == 0) begin
        chk("spurious_beat", 1, 0);
      end else begin
        b = q.pop_front();
        ref_norm(b.d, 15, em, es);
        chk("o_data", bus.o_data, em);
        chk("o_shift", bus.o_shift, es);
        chk("o_last", bus.o_last, b.l);
        if (bus.o_shift <= 4'd8) begin
          rt = (int'($signed(bus.o_data)) * 256) >>> int'(bus.o_shift);
          ex = int'($signed(b.d)) & ~((1 << (8 - int'(bus.o_shift))) - 1);
          chk("roundtrip", rt, ex);
        end
      end
    end
    prev_stall = bus.o_valid && !bus.i_ready;
    prev_out   = {bus.o_data, bus.o_shift, bus.o_last};
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit          acc;
    int          idx;
    int          sent;
    logic [15:0] dir_vals[6];
    logic [15:0] stall_vals[5];
    logic [15:0] m4_vals[6];
    logic [7:0]  em;
    logic [3:0]  es;

    dir_vals   = '{16'h0030, 16'hFFF0, 16'h7FFF, 16'h8000, 16'h0000, 16'hFFFF};
    stall_vals = '{16'h0001, 16'h0002, 16'h0100, 16'hFF00, 16'h1234};
    m4_vals    = '{16'h0003, 16'h0000, 16'hFFFF, 16'h0030, 16'h7FFF, 16'h0100};

    rst = 1'b1;
    bus.i_valid = 1'b0; bus.i_data = '0; bus.i_last = 1'b0; bus.i_ready = 1'b1;
    bus4.i_valid = 1'b0; bus4.i_data = '0; bus4.i_last = 1'b0; bus4.i_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_o_valid", bus.o_valid, 0);
    chk("rst_o_data", bus.o_data, 0);
    chk("rst_o_shift", bus.o_shift, 0);
    chk("rst_o_last", bus.o_last, 0);
    chk("rst_o_ready", bus.o_ready, 1);
    @(negedge clk);

    // single beats: latency and boundary values
    foreach (dir_vals[i]) begin
      bus.i_valid = 1'b1;
      bus.i_data  = dir_vals[i];
      bus.i_last  = 1'($urandom);
      tick(acc);
      chk("single_accept", acc, 1);
      bus.i_valid = 1'b0;
      chk("lat1_valid", bus.o_valid, 0);
      tick(acc);
      chk("lat2_valid", bus.o_valid, 1);
      tick(acc);
    end

    // back-pressure with i_ready low for cycles 3..6
    idx = 0;
    for (int c = 0; c < 20; c++) begin
      bus.i_ready = !(c >= 3 && c <= 6);
      bus.i_valid = (idx < 5);
      bus.i_data  = (idx < 5) ? stall_vals[idx] : 16'h0;
      bus.i_last  = (idx == 4);
      if (c == 4) begin
        #1;
        chk("ready_full", bus.o_ready, 0);
      end
      tick(acc);
      if (acc) idx++;
    end
    chk("stall_sent", idx, 5);
    chk("stall_drain", q.size(), 0);

    // random stream
    sent = 0;
    for (int cyc = 0; cyc < 6000 && (sent < 1000 || q.size() > 0); cyc++) begin
      bus.i_valid = (sent < 1000) && ($urandom_range(0, 3) != 0);
      bus.i_data  = ($urandom_range(0, 3) == 0) ? 16'(int'($urandom_range(0, 64)) - 32)
                                                : 16'($urandom);
      bus.i_last  = 1'($urandom);
      bus.i_ready = ($urandom_range(0, 3) != 0);
      tick(acc);
      if (acc) sent++;
    end
    chk("rand_sent", sent, 1000);
    chk("rand_drain", q.size(), 0);

    // reset while both stages hold beats
    bus.i_ready = 1'b0;
    bus.i_valid = 1'b1;
    bus.i_data  = 16'h0123;
    tick(acc);
    bus.i_data  = 16'hF00F;
    tick(acc);
    bus.i_valid = 1'b0;
    #1;
    chk("pre_rst_ready", bus.o_ready, 0);
    chk("pre_rst_valid", bus.o_valid, 1);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_async_valid", bus.o_valid, 0);
    q.delete();
    prev_stall = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", bus.o_ready, 1);
    bus.i_ready = 1'b1;
    repeat (6) begin
      tick(acc);
      chk("no_stale_beat", bus.o_valid, 0);
    end

    // idle bus carrying X
    bus.i_valid = 1'b0;
    bus.i_data  = 'x;
    repeat (10) begin
      tick(acc);
      chk("idle_valid", bus.o_valid, 0);
      chk("idle_no_x", $isunknown({bus.o_data, bus.o_shift, bus.o_last}), 0);
    end
    bus.i_data = '0;

    // MAX_SHIFT=4 instance
    foreach (m4_vals[i]) begin
      bus4.i_valid = 1'b1;
      bus4.i_data  = m4_vals[i];
      bus4.i_last  = 1'b1;
      @(negedge clk);
      bus4.i_valid = 1'b0;
      @(negedge clk);
      #1;
      ref_norm(m4_vals[i], 4, em, es);
      chk("m4_valid", bus4.o_valid, 1);
      chk("m4_data", bus4.o_data, em);
      chk("m4_shift", bus4.o_shift, es);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
